// File: rtl/sc_regserial_tx_if.sv
// Parallel-load / serial-out bus of the register serial transmitter.
// The requester drives data and the active-low load strobe. The transmitter drives the line, busy and done.
interface sc_regserial_tx_if #(
  parameter int DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0] SC_REGSERIALTX_data_InBUS;
  logic                 SC_REGSERIALTX_load_InLow;
  logic                 SC_REGSERIALTX_serial_Out;
  logic                 SC_REGSERIALTX_busy_Out;
  logic                 SC_REGSERIALTX_done_OutLow;

  modport master (
    output SC_REGSERIALTX_data_InBUS,
    output SC_REGSERIALTX_load_InLow,
    input  SC_REGSERIALTX_serial_Out,
    input  SC_REGSERIALTX_busy_Out,
    input  SC_REGSERIALTX_done_OutLow
  );

  modport slave (
    input  SC_REGSERIALTX_data_InBUS,
    input  SC_REGSERIALTX_load_InLow,
    output SC_REGSERIALTX_serial_Out,
    output SC_REGSERIALTX_busy_Out,
    output SC_REGSERIALTX_done_OutLow
  );
endinterface

// File: rtl/sc_regserial_tx.sv
// Frames a parallel word as start(0), DATAWIDTH bits MSB first, stop(1) on a registered serial line.
// A falling edge of the active-low load strobe starts a frame. Each bit lasts BITPERIOD clocks.
module sc_regserial_tx #(
  parameter int DATAWIDTH = 8,
  parameter int BITPERIOD = 4
) (
  input  logic               SC_REGSERIALTX_CLOCK_50,
  input  logic               SC_REGSERIALTX_RESET_InLow,
  sc_regserial_tx_if.slave   bus
);
  localparam int BP_W = (BITPERIOD > 1) ? $clog2(BITPERIOD) : 1;
  localparam int BC_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [BP_W-1:0] BP_LAST = BP_W'(BITPERIOD - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATAWIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

  state_t               state_reg;
  logic [DATAWIDTH-1:0] shift_reg;
  logic [BP_W-1:0]      bp_cnt_reg;
  logic [BC_W-1:0]      bit_cnt_reg;
  logic                 load_prev_reg;
  logic                 serial_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic                 request;
  logic                 bp_last;
  logic [DATAWIDTH-1:0] shift_next;

  // load_prev resets to 0, so a strobe held low across reset release is not an edge
  assign request    = load_prev_reg & ~bus.SC_REGSERIALTX_load_InLow;
  assign bp_last    = (bp_cnt_reg == BP_LAST);
  assign shift_next = shift_reg << 1;

  always_ff @(posedge SC_REGSERIALTX_CLOCK_50 or negedge SC_REGSERIALTX_RESET_InLow) begin
    if (!SC_REGSERIALTX_RESET_InLow) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bp_cnt_reg    <= '0;
      bit_cnt_reg   <= '0;
      load_prev_reg <= 1'b0;
      serial_reg    <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b1;
    end else begin
      load_prev_reg <= bus.SC_REGSERIALTX_load_InLow;
      done_reg      <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (request) begin
            shift_reg  <= bus.SC_REGSERIALTX_data_InBUS;
            state_reg  <= START;
            busy_reg   <= 1'b1;
            serial_reg <= 1'b0;
            bp_cnt_reg <= '0;
          end
        end
        START: begin
          if (bp_last) begin
            bp_cnt_reg  <= '0;
            bit_cnt_reg <= '0;
            serial_reg  <= shift_reg[DATAWIDTH-1];
            state_reg   <= SHIFT;
          end else begin
            bp_cnt_reg <= bp_cnt_reg + 1'b1;
          end
        end
        SHIFT: begin
          if (bp_last) begin
            bp_cnt_reg <= '0;
            if (bit_cnt_reg == BC_LAST) begin
              serial_reg <= 1'b1;
              state_reg  <= STOP;
            end else begin
              shift_reg   <= shift_next;
              serial_reg  <= shift_next[DATAWIDTH-1];
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else begin
            bp_cnt_reg <= bp_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (bp_last) begin
            bp_cnt_reg <= '0;
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
          end else begin
            bp_cnt_reg <= bp_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.SC_REGSERIALTX_serial_Out  = serial_reg;
  assign bus.SC_REGSERIALTX_busy_Out    = busy_reg;
  assign bus.SC_REGSERIALTX_done_OutLow = done_reg;
endmodule

// File: tb/tb_sc_regserial_tx.sv
// Directed bench for sc_regserial_tx: one 8-bit instance with 4-cycle bits, and one with 1-cycle bits.
// Both share the clock and the asynchronous reset.
module tb_sc_regserial_tx;
  logic clk;
  logic rst_n;

  int vectors;
  int fails;

  sc_regserial_tx_if #(.DATAWIDTH(8)) bus4 ();
  sc_regserial_tx_if #(.DATAWIDTH(8)) bus1 ();

  sc_regserial_tx #(.DATAWIDTH(8), .BITPERIOD(4)) dut4 (
    .SC_REGSERIALTX_CLOCK_50   (clk),
    .SC_REGSERIALTX_RESET_InLow(rst_n),
    .bus                       (bus4.slave)
  );

  sc_regserial_tx #(.DATAWIDTH(8), .BITPERIOD(1)) dut1 (
    .SC_REGSERIALTX_CLOCK_50   (clk),
    .SC_REGSERIALTX_RESET_InLow(rst_n),
    .bus                       (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle4(input string tag);
    check_vec({tag, " serial"}, 32'(bus4.SC_REGSERIALTX_serial_Out), 32'd1);
    check_vec({tag, " busy"},   32'(bus4.SC_REGSERIALTX_busy_Out),   32'd0);
    check_vec({tag, " done"},   32'(bus4.SC_REGSERIALTX_done_OutLow), 32'd1);
  endtask

  // Frame on the B=4 instance. Cycle c is sampled at the negedge after acceptance edge k+c.
  // bits[9] is the first bit on the line. abort_at >= 0 asserts reset after that cycle.
  task automatic send_frame4(input logic [7:0] d, input logic [9:0] bits,
                             input int abort_at, input bit disturb, input string tag);
    @(negedge clk);
    bus4.SC_REGSERIALTX_load_InLow = 1'b1;
    @(negedge clk);
    bus4.SC_REGSERIALTX_data_InBUS = d;
    bus4.SC_REGSERIALTX_load_InLow = 1'b0;
    @(posedge clk);
    for (int c = 0; c <= 41; c++) begin
      @(negedge clk);
      if (c < 40) begin
        check_vec($sformatf("%s c%0d serial", tag, c), 32'(bus4.SC_REGSERIALTX_serial_Out), 32'(bits[9 - c / 4]));
        check_vec($sformatf("%s c%0d busy", tag, c),   32'(bus4.SC_REGSERIALTX_busy_Out),   32'd1);
        check_vec($sformatf("%s c%0d done", tag, c),   32'(bus4.SC_REGSERIALTX_done_OutLow), 32'd1);
      end else if (c == 40) begin
        check_vec({tag, " end serial"}, 32'(bus4.SC_REGSERIALTX_serial_Out), 32'd1);
        check_vec({tag, " end busy"},   32'(bus4.SC_REGSERIALTX_busy_Out),   32'd0);
        check_vec({tag, " end done"},   32'(bus4.SC_REGSERIALTX_done_OutLow), 32'd0);
      end else begin
        check_idle4({tag, " after"});
      end
      if (abort_at >= 0 && c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_idle4({tag, " abort"});
        return;
      end
      if (disturb) begin
        if (c == 0) bus4.SC_REGSERIALTX_data_InBUS = 8'hFF;
        if (c == 8) bus4.SC_REGSERIALTX_load_InLow = 1'b1;
        if (c == 9) bus4.SC_REGSERIALTX_load_InLow = 1'b0;
      end
    end
  endtask

  initial begin
    logic [9:0] bits1;
    vectors = 0;
    fails   = 0;
    rst_n   = 1'b0;
    bus4.SC_REGSERIALTX_data_InBUS = 8'h00;
    bus4.SC_REGSERIALTX_load_InLow = 1'b1;
    bus1.SC_REGSERIALTX_data_InBUS = 8'h00;
    bus1.SC_REGSERIALTX_load_InLow = 1'b0;   // held low across reset release

    repeat (3) @(negedge clk);
    check_idle4("reset");
    check_vec("reset b1 busy", 32'(bus1.SC_REGSERIALTX_busy_Out), 32'd0);
    rst_n = 1'b1;

    // Idle with load high; B=1 instance must ignore its held-low strobe
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle4($sformatf("idle%0d", i));
      check_vec($sformatf("idle%0d b1 busy", i), 32'(bus1.SC_REGSERIALTX_busy_Out), 32'd0);
    end

    // 0xA5: 0 10100101 1
    send_frame4(8'hA5, 10'b0101001011, -1, 1'b0, "a5");

    // Held low for 100 cycles: no second frame
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus4.SC_REGSERIALTX_busy_Out !== 1'b0 || i % 25 == 0)
        check_vec($sformatf("hold%0d busy", i), 32'(bus4.SC_REGSERIALTX_busy_Out), 32'd0);
    end

    // 0x3C: 0 00111100 1
    send_frame4(8'h3C, 10'b0001111001, -1, 1'b0, "3c");

    // Data changed and a second strobe edge mid-frame: frame still 0xA5
    send_frame4(8'hA5, 10'b0101001011, -1, 1'b1, "dist");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle4($sformatf("dist post%0d", i));
    end

    // Abort mid-frame with reset
    send_frame4(8'h5A, 10'b0010110101, 16, 1'b0, "abort");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle4($sformatf("inrst%0d", i));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle4($sformatf("postrst%0d", i));
    end

    // 0xC3: 0 11000011 1
    send_frame4(8'hC3, 10'b0110000111, -1, 1'b0, "c3");

    // B=1, 0x80: 0 10000000 1 on consecutive cycles
    bits1 = 10'b0100000001;
    @(negedge clk);
    bus1.SC_REGSERIALTX_load_InLow = 1'b1;
    @(negedge clk);
    bus1.SC_REGSERIALTX_data_InBUS = 8'h80;
    bus1.SC_REGSERIALTX_load_InLow = 1'b0;
    @(posedge clk);
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      if (c < 10) begin
        check_vec($sformatf("b1 c%0d serial", c), 32'(bus1.SC_REGSERIALTX_serial_Out), 32'(bits1[9 - c]));
        check_vec($sformatf("b1 c%0d busy", c),   32'(bus1.SC_REGSERIALTX_busy_Out),   32'd1);
        check_vec($sformatf("b1 c%0d done", c),   32'(bus1.SC_REGSERIALTX_done_OutLow), 32'd1);
      end else begin
        check_vec($sformatf("b1 c%0d serial", c), 32'(bus1.SC_REGSERIALTX_serial_Out), 32'd1);
        check_vec($sformatf("b1 c%0d busy", c),   32'(bus1.SC_REGSERIALTX_busy_Out),   32'd0);
        check_vec($sformatf("b1 c%0d done", c),   32'(bus1.SC_REGSERIALTX_done_OutLow), (c == 10) ? 32'd0 : 32'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
